// File: rtl/timing_beat_gen.sv
// Beat timing for the hardwired controller: phase pulses T1/T2/T3 and one-hot machine cycles W1/W2/W3.
// Optional single-instruction step mode is enabled by defining TIMING_BEAT_STEP_EN.
module timing_beat_gen #(
  parameter int PHASE_LEN = 1,
  parameter int BEAT_W    = 16
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              QD,
  input  logic              STOP,
  input  logic              SHORT,
  input  logic              LONG,
`ifdef TIMING_BEAT_STEP_EN
  input  logic              STEP_MODE,
`endif
  output logic              T1,
  output logic              T2,
  output logic              T3,
  output logic              W1,
  output logic              W2,
  output logic              W3,
  output logic              RUN,
  output logic [BEAT_W-1:0] BEAT_CNT
);

  localparam int PW = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
  localparam logic [PW-1:0] LAST_PH = PW'(PHASE_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_T3} state_t;

  state_t            r_state;
  logic [PW-1:0]     r_ph_cnt;
  logic              r_qd_d;
  logic              r_t1, r_t2, r_t3, r_run;
  logic [2:0]        r_w;
  logic [BEAT_W-1:0] r_cnt;

  logic       w_start;
  logic       w_last;
  logic [2:0] w_next_w;
  logic       w_halt;

  assign w_start = QD & ~r_qd_d & ~r_run;
  assign w_last  = (r_ph_cnt == LAST_PH);

  // Any encoding other than W1/W2/W3 falls back to W1.
  always_comb begin
    w_next_w = 3'b001;
    case (r_w)
      3'b001:  w_next_w = SHORT ? 3'b001 : 3'b010;
      3'b010:  w_next_w = LONG  ? 3'b100 : 3'b001;
      default: w_next_w = 3'b001;
    endcase
  end

`ifdef TIMING_BEAT_STEP_EN
  assign w_halt = STOP | (STEP_MODE & (w_next_w == 3'b001));
`else
  assign w_halt = STOP;
`endif

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state  <= S_IDLE;
      r_ph_cnt <= '0;
      r_qd_d   <= 1'b0;
      r_t1     <= 1'b0;
      r_t2     <= 1'b0;
      r_t3     <= 1'b0;
      r_run    <= 1'b0;
      r_w      <= 3'b001;
      r_cnt    <= '0;
    end else begin
      r_qd_d <= QD;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state  <= S_T1;
            r_ph_cnt <= '0;
            r_t1     <= 1'b1;
            r_run    <= 1'b1;
          end
        end
        S_T1: begin
          if (w_last) begin
            r_state  <= S_T2;
            r_ph_cnt <= '0;
            r_t1     <= 1'b0;
            r_t2     <= 1'b1;
          end else begin
            r_ph_cnt <= r_ph_cnt + 1'b1;
          end
        end
        S_T2: begin
          if (w_last) begin
            r_state  <= S_T3;
            r_ph_cnt <= '0;
            r_t2     <= 1'b0;
            r_t3     <= 1'b1;
          end else begin
            r_ph_cnt <= r_ph_cnt + 1'b1;
          end
        end
        S_T3: begin
          if (w_last) begin
            // Beat end: controller requests are only honoured here.
            r_ph_cnt <= '0;
            r_t3     <= 1'b0;
            r_w      <= w_next_w;
            r_cnt    <= r_cnt + 1'b1;
            if (w_halt) begin
              r_state <= S_IDLE;
              r_run   <= 1'b0;
            end else begin
              r_state <= S_T1;
              r_t1    <= 1'b1;
            end
          end else begin
            r_ph_cnt <= r_ph_cnt + 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_ph_cnt <= '0;
          r_t1     <= 1'b0;
          r_t2     <= 1'b0;
          r_t3     <= 1'b0;
          r_run    <= 1'b0;
        end
      endcase
    end
  end

  assign T1       = r_t1;
  assign T2       = r_t2;
  assign T3       = r_t3;
  assign W1       = r_w[0];
  assign W2       = r_w[1];
  assign W3       = r_w[2];
  assign RUN      = r_run;
  assign BEAT_CNT = r_cnt;

endmodule
